// File: rtl/muldiv_pkg.sv
// Shared op and state encodings for the iterative multiply/divide unit,
// plus small decode helpers used by the control logic.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    function automatic logic is_iter_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the datapath: shift-add for multiply (acc_lo holds the
// multiplier), restoring subtract-shift for divide (acc_hi = remainder, acc_lo = quotient).
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] next_hi,
    output logic [WIDTH-1:0] next_lo
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] partial;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        sum     = {1'b0, acc_hi} + {1'b0, operand};
        partial = acc_lo[0] ? sum : {1'b0, acc_hi};
        shifted = {acc_hi, acc_lo[WIDTH-1]};
        // diff[WIDTH] is the borrow: set when the shifted remainder is below the divisor
        diff    = shifted - {1'b0, operand};
        if (is_div) begin
            next_hi = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            next_lo = {acc_lo[WIDTH-2:0], ~diff[WIDTH]};
        end else begin
            next_hi = partial[WIDTH:1];
            next_lo = {partial[0], acc_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// MIPS-style HI/LO multiply/divide unit: magnitude iteration for WIDTH cycles,
// then a single sign-correction cycle that commits HI/LO.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_e             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic [WIDTH-1:0]   acc_hi_reg, acc_lo_reg, operand_reg;
    logic [WIDTH-1:0]   hi_reg, lo_reg;
    logic               is_div_reg, neg_hi_reg, neg_lo_reg;
    logic               pend_reg, done_reg;

    logic               req, accept, div_zero, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag, step_hi, step_lo, fix_hi, fix_lo;
    logic [2*WIDTH-1:0] prod;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (is_div_reg),
        .acc_hi  (acc_hi_reg),
        .acc_lo  (acc_lo_reg),
        .operand (operand_reg),
        .next_hi (step_hi),
        .next_lo (step_lo)
    );

    always_comb begin
        req      = (state_reg == ST_IDLE) && start && !flush;
        accept   = req && is_iter_op(op);
        div_zero = is_div_op(op) && (b == '0);
        a_neg    = is_signed_op(op) && a[WIDTH-1];
        b_neg    = is_signed_op(op) && b[WIDTH-1];
        a_mag    = a_neg ? -a : a;
        b_mag    = b_neg ? -b : b;
        prod     = {acc_hi_reg, acc_lo_reg};
        fix_hi   = acc_hi_reg;
        fix_lo   = acc_lo_reg;
        if (!is_div_reg) begin
            if (neg_lo_reg) {fix_hi, fix_lo} = -prod;
        end else begin
            if (neg_hi_reg) fix_hi = -acc_hi_reg;
            if (neg_lo_reg) fix_lo = -acc_lo_reg;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept) state_next = div_zero ? ST_FIX : ST_CALC;
            ST_CALC: begin
                if (flush)                          state_next = ST_IDLE;
                else if (cnt_reg == CNT_W'(1))      state_next = ST_FIX;
            end
            ST_FIX:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_reg <= ST_IDLE;
        else     state_reg <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg     <= '0;
            acc_hi_reg  <= '0;
            acc_lo_reg  <= '0;
            operand_reg <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            is_div_reg  <= 1'b0;
            neg_hi_reg  <= 1'b0;
            neg_lo_reg  <= 1'b0;
            pend_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            pend_reg <= 1'b0;
            done_reg <= pend_reg;
            if (req && (op == OP_MTHI)) hi_reg <= a;
            if (req && (op == OP_MTLO)) lo_reg <= a;
            if (accept) begin
                is_div_reg <= is_div_op(op);
                cnt_reg    <= CNT_W'(WIDTH);
                if (div_zero) begin
                    // Result is forced: FIX passes hi=a, lo=all ones through uncorrected
                    acc_hi_reg  <= a;
                    acc_lo_reg  <= '1;
                    operand_reg <= '0;
                    neg_hi_reg  <= 1'b0;
                    neg_lo_reg  <= 1'b0;
                end else if (is_div_op(op)) begin
                    acc_hi_reg  <= '0;
                    acc_lo_reg  <= a_mag;
                    operand_reg <= b_mag;
                    neg_hi_reg  <= a_neg;
                    neg_lo_reg  <= a_neg ^ b_neg;
                end else begin
                    acc_hi_reg  <= '0;
                    acc_lo_reg  <= b_mag;
                    operand_reg <= a_mag;
                    neg_hi_reg  <= a_neg ^ b_neg;
                    neg_lo_reg  <= a_neg ^ b_neg;
                end
            end
            if ((state_reg == ST_CALC) && !flush) begin
                acc_hi_reg <= step_hi;
                acc_lo_reg <= step_lo;
                cnt_reg    <= cnt_reg - CNT_W'(1);
            end
            if ((state_reg == ST_FIX) && !flush) begin
                hi_reg   <= fix_hi;
                lo_reg   <= fix_lo;
                pend_reg <= 1'b1;
            end
        end
    end

    assign busy = (state_reg != ST_IDLE);
    assign done = done_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit at WIDTH=32; one line per transaction.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        flush;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_cmp = 0;
    int n_err = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one iterative op; lat = edges from acceptance until done is seen (-1 on timeout)
    task automatic run_op(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb,
                          output int lat);
        @(negedge clk);
        start = 1'b1; op = o; a = va; b = vb;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        $display("op=%0d a=0x%08h b=0x%08h -> hi=0x%08h lo=0x%08h latency=%0d", o, va, vb, hi, lo, lat);
    endtask

    task automatic pulse_op(input logic [2:0] o, input logic [31:0] va, input logic fl);
        @(negedge clk);
        start = 1'b1; op = o; a = va; flush = fl;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        $display("op=%0d a=0x%08h flush=%0d -> hi=0x%08h lo=0x%08h busy=%0d", o, va, fl, hi, lo, busy);
    endtask

    task automatic watch_no_done(input string tag, input int cycles);
        int seen = 0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        check(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        int lat;
        rst = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        $display("reset: busy=%0d done=%0d hi=0x%08h lo=0x%08h", busy, done, hi, lo);
        @(negedge clk) rst = 1'b0;

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, lat);
        check("mult_lat", 64'(lat), 64'd34);
        check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
        check("mult_lo", 64'(lo), 64'hFFFF_FFEB);

        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        check("multu_hi", 64'(hi), 64'hFFFF_FFFE);
        check("multu_lo", 64'(lo), 64'h0000_0001);

        run_op(3'd3, 32'd100, 32'd7, lat);
        check("divu_lat", 64'(lat), 64'd34);
        check("divu_lo", 64'(lo), 64'd14);
        check("divu_hi", 64'(hi), 64'd2);

        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, lat);
        check("div_neg_lo", 64'(lo), 64'hFFFF_FFFD);
        check("div_neg_hi", 64'(hi), 64'hFFFF_FFFF);

        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        check("div_ovf_lo", 64'(lo), 64'h8000_0000);
        check("div_ovf_hi", 64'(hi), 64'h0);

        run_op(3'd3, 32'h1234, 32'd0, lat);
        check("div0_lat", 64'(lat), 64'd2);
        check("div0_hi", 64'(hi), 64'h1234);
        check("div0_lo", 64'(lo), 64'hFFFF_FFFF);

        // MULT accepted at edge 0, ignored start at edge 5, flush at edge 10
        @(negedge clk);
        start = 1'b1; op = 3'd0; a = 32'd5; b = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        check("flush_busy_on", 64'(busy), 64'd1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1; op = 3'd3; a = 32'd50; b = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk) flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy_off", 64'(busy), 64'd0);
        watch_no_done("flush_no_done", 40);
        check("flush_hi", 64'(hi), 64'h1234);
        check("flush_lo", 64'(lo), 64'hFFFF_FFFF);
        $display("flush: busy=%0d hi=0x%08h lo=0x%08h", busy, hi, lo);

        pulse_op(3'd5, 32'hA5A5_A5A5, 1'b0);
        check("mtlo_lo", 64'(lo), 64'hA5A5_A5A5);
        check("mtlo_busy", 64'(busy), 64'd0);
        watch_no_done("mtlo_no_done", 3);

        pulse_op(3'd4, 32'hDEAD_BEEF, 1'b1);
        check("mthi_flushed", 64'(hi), 64'h1234);

        pulse_op(3'd4, 32'hCAFE_0001, 1'b0);
        check("mthi_hi", 64'(hi), 64'hCAFE_0001);

        pulse_op(3'd7, 32'h5555_5555, 1'b0);
        check("rsvd_busy", 64'(busy), 64'd0);
        check("rsvd_hi", 64'(hi), 64'hCAFE_0001);

        @(negedge clk);
        start = 1'b1; op = 3'd1; a = 32'd3; b = 32'd4;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        check("rstmid_busy", 64'(busy), 64'd0);
        check("rstmid_hi", 64'(hi), 64'd0);
        check("rstmid_lo", 64'(lo), 64'd0);
        @(negedge clk) rst = 1'b0;
        watch_no_done("rstmid_no_done", 40);
        $display("reset mid-calc: busy=%0d hi=0x%08h lo=0x%08h", busy, hi, lo);

        run_op(3'd0, 32'hFFFF_FFFA, 32'hFFFF_FFFB, lat);
        check("mult_nn_lat", 64'(lat), 64'd34);
        check("mult_nn_hi", 64'(hi), 64'h0);
        check("mult_nn_lo", 64'(lo), 64'd30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
